mult_div_unit: RTL and testbench
================================

# mult_div_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, the successor to the single-cycle ALU multiply path. It executes MIPS-style MULT/MULTU/DIV/DIVU iteratively at a configurable width and multiply radix, plus MTHI/MTLO writes. It sits beside the datapath ALU; the pipeline controller issues operations through a start/busy/done handshake and reads HI/LO directly.

## Interface

- WIDTH, 32, operand width and HI/LO width; even, ≥ 4.
- MUL_STEP, 2, multiplier bits retired per cycle; must divide WIDTH (1, 2 or 4).

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  operation request; accepted only when busy = 0.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored (no effect).
- a  input  WIDTH  operand A (multiplicand / dividend / MTHI/MTLO source).
- b  input  WIDTH  operand B (multiplier / divisor).
- busy  output  1  operation in progress; start ignored while high.
- done  output  1  one-cycle completion pulse for MULT/MULTU/DIV/DIVU.
- div_by_zero  output  1  set with done when DIV/DIVU had b = 0; held until next accepted start.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).

## Operation

- States: IDLE, RUN, FINISH.
- IDLE: on edge with start = 1, latch operands and op, clear div_by_zero and done.
  - MTHI/MTLO: hi (resp. lo) <= a on that edge; stay IDLE, no busy, no done.
  - MULT/MULTU: load step counter = WIDTH/MUL_STEP, go RUN.
  - DIV/DIVU with b ≠ 0: counter = WIDTH, go RUN. With b = 0: go FINISH directly.
  - Unused op codes: stay IDLE, nothing changes.
- Signed ops: operands replaced by magnitudes at accept; sign flags recorded. MULTU/DIVU treat operands as unsigned.
- RUN (multiply): shift-add over MUL_STEP multiplier bits per cycle into a 2·WIDTH accumulator; counter decrements; counter reaching 0 → FINISH.
- RUN (divide): restoring division, one quotient bit per cycle, WIDTH-bit partial remainder plus 1 guard bit.
- FINISH: apply sign correction and write HI/LO, pulse done, return IDLE.
  - MULT: 2·WIDTH product negated (two's complement) if sign(a) ≠ sign(b).
  - DIV: quotient negated if signs differ; remainder takes sign of dividend (truncating division). Most-negative / −1 → lo = most-negative value (wraps), hi = 0.
  - Divide by zero: hi/lo unchanged, div_by_zero = 1.
- hi/lo hold their previous values throughout RUN; update only in FINISH or MTHI/MTLO.
- start while busy = 1 is ignored; no queueing.

## Timing

- Reset: state IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0, internal accumulators cleared. Reset mid-operation aborts; no result written after release.
- busy rises the cycle after start is accepted (combinational on state ≠ IDLE) and stays high K+1 cycles: K = WIDTH/MUL_STEP (mult), K = WIDTH (div), K = 0 (divide by zero).
- done = 1 and new hi/lo visible in the first cycle with busy = 0; done lasts exactly one cycle.
- New start may be accepted in that same done cycle (back-to-back issue).
- MTHI/MTLO: hi/lo updated the cycle after the accepting edge.
- WIDTH=32, MUL_STEP=2: mult busy 17 cycles, div busy 33 cycles, div-by-zero busy 1 cycle.

## Test plan

- Reset then MULT a=5, b=4 → busy 17 cycles, done pulse, hi=0, lo=20; MULTU a=4, b=3 → lo=12.
- MULTU a=0xFFFFFFFF, b=2111222333 → hi=2111222332, lo=2183744963; MULT same operands → hi=0xFFFFFFFF, lo=2183744963; MULT a=−2113, b=2 → hi=0xFFFFFFFF, lo=0xFFFFEF7E.
- DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 → lo=3, hi=1; DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0; each busy 33 cycles.
- MTHI a=0x1234, MTLO a=0x5678, then DIVU b=0 → busy 1 cycle, done with div_by_zero=1, hi=0x1234, lo=0x5678 unchanged; next accepted start clears div_by_zero.
- Start pulses with different op during busy → ignored, result matches first op; back-to-back start in done cycle accepted.
- Assert rst_n=0 mid-MULT → all outputs 0 immediately; after release no done pulse; repeat all checks with WIDTH=16, MUL_STEP=4 (mult busy 5 cycles).

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO registers.
// Radix-2^MUL_STEP shift-add multiply, restoring divide, start/busy/done handshake.
module mult_div_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;
    localparam logic [CW-1:0] MUL_CNT = CW'(WIDTH / MUL_STEP);
    localparam logic [CW-1:0] DIV_CNT = CW'(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               dbz_pend_q, dbz_pend_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic                      sgn, a_neg, b_neg;
    logic [WIDTH-1:0]          a_mag, b_mag;
    logic [MUL_STEP-1:0]       mbits;
    logic [WIDTH+MUL_STEP-1:0] partial, msum;
    logic [2*WIDTH-1:0]        mul_next, div_next, prod_fix;
    logic [WIDTH:0]            trial, diff;
    logic [WIDTH-1:0]          quot_fix, rem_fix;

    // One multiply step: add multiplicand times the low MUL_STEP multiplier bits
    // into the upper half, then shift the whole accumulator right.
    always_comb begin
        mbits    = acc_q[MUL_STEP-1:0];
        partial  = {{MUL_STEP{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, mbits};
        msum     = {{MUL_STEP{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + partial;
        mul_next = {msum, acc_q[WIDTH-1:MUL_STEP]};

        trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff  = trial - {1'b0, opnd_q};
        if (!diff[WIDTH])
            div_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
            div_next = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

        prod_fix = neg_lo_q ? -acc_q : acc_q;
        quot_fix = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        sgn   = ~op[2] & ~op[0];
        a_neg = sgn & a[WIDTH-1];
        b_neg = sgn & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;

        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        dbz_pend_d = dbz_pend_q;
        dbz_d      = dbz_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        3'b000, 3'b001: begin
                            state_d    = S_RUN;
                            count_d    = MUL_CNT;
                            acc_d      = {{WIDTH{1'b0}}, b_mag};
                            opnd_d     = a_mag;
                            is_div_d   = 1'b0;
                            neg_lo_d   = a_neg ^ b_neg;
                            neg_hi_d   = a_neg ^ b_neg;
                            dbz_pend_d = 1'b0;
                            dbz_d      = 1'b0;
                        end
                        3'b010, 3'b011: begin
                            acc_d      = {{WIDTH{1'b0}}, a_mag};
                            opnd_d     = b_mag;
                            is_div_d   = 1'b1;
                            neg_lo_d   = a_neg ^ b_neg;
                            neg_hi_d   = a_neg;
                            dbz_d      = 1'b0;
                            dbz_pend_d = (b == '0);
                            state_d    = (b == '0) ? S_FINISH : S_RUN;
                            count_d    = DIV_CNT;
                        end
                        3'b100: begin
                            hi_d  = a;
                            dbz_d = 1'b0;
                        end
                        3'b101: begin
                            lo_d  = a;
                            dbz_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                acc_d   = is_div_q ? div_next : mul_next;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1))
                    state_d = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (dbz_pend_q) begin
                    dbz_d = 1'b1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dbz_pend_q <= 1'b0;
            dbz_q      <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            dbz_pend_q <= dbz_pend_d;
            dbz_q      <= dbz_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a 32-bit/radix-4 and a 16-bit/radix-16
// instance checked against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        start32, start16;
    logic        busy32, done32, dbz32;
    logic [31:0] hi32, lo32;
    logic        busy16, done16, dbz16;
    logic [15:0] hi16, lo16;

    logic        sel16;
    logic        busy_m, done_m, dbz_m;
    logic [31:0] hi_m, lo_m;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          busy;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mhi[2];
    logic [31:0] mlo[2];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32), .MUL_STEP(2)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .op(op), .a(a), .b(b),
        .busy(busy32), .done(done32), .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
    );

    mult_div_unit #(.WIDTH(16), .MUL_STEP(4)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .op(op), .a(a[15:0]), .b(b[15:0]),
        .busy(busy16), .done(done16), .div_by_zero(dbz16), .hi(hi16), .lo(lo16)
    );

    assign busy_m = sel16 ? busy16 : busy32;
    assign done_m = sel16 ? done16 : done32;
    assign dbz_m  = sel16 ? dbz16 : dbz32;
    assign hi_m   = sel16 ? {16'h0, hi16} : hi32;
    assign lo_m   = sel16 ? {16'h0, lo16} : lo32;

    // Reference results from plain 64-bit integer arithmetic.
    function automatic exp_t model(input int w, input logic [2:0] o,
                                   input logic [31:0] av, input logic [31:0] bv,
                                   input logic [31:0] ph, input logic [31:0] pl);
        exp_t r;
        longint unsigned mask, ua, ub, pu;
        longint sa, sb, q, rm;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'd0, av} & mask;
        ub = {32'd0, bv} & mask;
        sa = ((ua >> (w - 1)) & 64'd1) != 0 ? longint'(ua) - longint'(mask + 64'd1) : longint'(ua);
        sb = ((ub >> (w - 1)) & 64'd1) != 0 ? longint'(ub) - longint'(mask + 64'd1) : longint'(ub);
        r.hi = ph; r.lo = pl; r.dbz = 1'b0; r.busy = 0;
        case (o)
            3'd0, 3'd1: begin
                pu = (o == 3'd0) ? longint'(sa * sb) : ua * ub;
                r.hi = 32'((pu >> w) & mask);
                r.lo = 32'(pu & mask);
                r.busy = w / ((w == 16) ? 4 : 2) + 1;
            end
            3'd2, 3'd3: begin
                if (ub == 64'd0) begin
                    r.dbz = 1'b1;
                    r.busy = 1;
                end else begin
                    if (o == 3'd2) begin
                        q = sa / sb; rm = sa % sb;
                    end else begin
                        q = longint'(ua / ub); rm = longint'(ua % ub);
                    end
                    r.lo = 32'(longint'(q) & longint'(mask));
                    r.hi = 32'(longint'(rm) & longint'(mask));
                    r.busy = w + 1;
                end
            end
            3'd4: r.hi = 32'(ua);
            3'd5: r.lo = 32'(ua);
            default: ;
        endcase
        return r;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        int idx;
        idx = sel16 ? 1 : 0;
        e = model(sel16 ? 16 : 32, o, av, bv, mhi[idx], mlo[idx]);
        if (o <= 3'd3) sb_q.push_back(e);
        mhi[idx] = e.hi;
        mlo[idx] = e.lo;
        op = o; a = av; b = bv;
        if (sel16) start16 = 1'b1; else start32 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        start32 = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (busy_m === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start32 = 1'b0; start16 = 1'b0; op = 3'd0; a = '0; b = '0; sel16 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({busy32, done32, dbz32} !== 3'b000) begin failures++; $display("[TB] FAIL reset_ctrl32: got %b expected 000", {busy32, done32, dbz32}); end
        checks++; if ({hi32, lo32} !== 64'd0) begin failures++; $display("[TB] FAIL reset_hilo32: got %h expected 0", {hi32, lo32}); end
        checks++; if ({busy16, done16, dbz16} !== 3'b000) begin failures++; $display("[TB] FAIL reset_ctrl16: got %b expected 000", {busy16, done16, dbz16}); end
        checks++; if ({hi16, lo16} !== 32'd0) begin failures++; $display("[TB] FAIL reset_hilo16: got %h expected 0", {hi16, lo16}); end
        rst_n = 1'b1;
        mhi[0] = '0; mlo[0] = '0; mhi[1] = '0; mlo[1] = '0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        logic [2:0]  t_op[5];
        logic [31:0] t_a[5];
        logic [31:0] t_b[5];
        exp_t e;
        int cnt;
        t_op = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd0};
        t_a  = '{32'd5, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_F7BF};
        t_b  = '{32'd4, 32'd3, 32'd2111222333, 32'd2111222333, 32'd2};
        sel16 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            wait_done(cnt);
            e = sb_q.pop_front();
            checks++; if (cnt !== e.busy) begin failures++; $display("[TB] FAIL mult%0d_busy: got %0d expected %0d", i, cnt, e.busy); end
            checks++; if (done_m !== 1'b1) begin failures++; $display("[TB] FAIL mult%0d_done: got %b expected 1", i, done_m); end
            checks++; if (hi_m !== e.hi) begin failures++; $display("[TB] FAIL mult%0d_hi: got %h expected %h", i, hi_m, e.hi); end
            checks++; if (lo_m !== e.lo) begin failures++; $display("[TB] FAIL mult%0d_lo: got %h expected %h", i, lo_m, e.lo); end
            @(negedge clk);
            checks++; if (done_m !== 1'b0) begin failures++; $display("[TB] FAIL mult%0d_done_pulse: got %b expected 0", i, done_m); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  t_op[4];
        logic [31:0] t_a[4];
        logic [31:0] t_b[4];
        exp_t e;
        int cnt;
        t_op = '{3'd2, 3'd3, 3'd2, 3'd2};
        t_a  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd1000};
        t_b  = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        sel16 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            wait_done(cnt);
            e = sb_q.pop_front();
            checks++; if (cnt !== e.busy) begin failures++; $display("[TB] FAIL div%0d_busy: got %0d expected %0d", i, cnt, e.busy); end
            checks++; if (done_m !== 1'b1) begin failures++; $display("[TB] FAIL div%0d_done: got %b expected 1", i, done_m); end
            checks++; if (hi_m !== e.hi) begin failures++; $display("[TB] FAIL div%0d_hi: got %h expected %h", i, hi_m, e.hi); end
            checks++; if (lo_m !== e.lo) begin failures++; $display("[TB] FAIL div%0d_lo: got %h expected %h", i, lo_m, e.lo); end
            checks++; if (dbz_m !== 1'b0) begin failures++; $display("[TB] FAIL div%0d_dbz: got %b expected 0", i, dbz_m); end
        end
    endtask

    task automatic test_div_by_zero();
        exp_t e;
        int cnt;
        sel16 = 1'b0;
        issue(3'd4, 32'h1234, 32'd0);
        checks++; if (hi_m !== 32'h1234) begin failures++; $display("[TB] FAIL mthi_hi: got %h expected 00001234", hi_m); end
        checks++; if ({busy_m, done_m} !== 2'b00) begin failures++; $display("[TB] FAIL mthi_ctrl: got %b expected 00", {busy_m, done_m}); end
        issue(3'd5, 32'h5678, 32'd0);
        checks++; if (lo_m !== 32'h5678) begin failures++; $display("[TB] FAIL mtlo_lo: got %h expected 00005678", lo_m); end
        issue(3'd3, 32'd9, 32'd0);
        wait_done(cnt);
        e = sb_q.pop_front();
        checks++; if (cnt !== e.busy) begin failures++; $display("[TB] FAIL dbz_busy: got %0d expected %0d", cnt, e.busy); end
        checks++; if (done_m !== 1'b1) begin failures++; $display("[TB] FAIL dbz_done: got %b expected 1", done_m); end
        checks++; if (dbz_m !== e.dbz) begin failures++; $display("[TB] FAIL dbz_flag: got %b expected %b", dbz_m, e.dbz); end
        checks++; if ({hi_m, lo_m} !== {e.hi, e.lo}) begin failures++; $display("[TB] FAIL dbz_hilo: got %h expected %h", {hi_m, lo_m}, {e.hi, e.lo}); end
        @(negedge clk);
        checks++; if (dbz_m !== 1'b1) begin failures++; $display("[TB] FAIL dbz_hold: got %b expected 1", dbz_m); end
        issue(3'd6, 32'hAAAA, 32'd0);
        checks++; if ({dbz_m, busy_m, hi_m} !== {2'b10, mhi[0]}) begin failures++; $display("[TB] FAIL unused_op: got %b/%h expected 10/%h", {dbz_m, busy_m}, hi_m, mhi[0]); end
        issue(3'd5, 32'h0042, 32'd0);
        checks++; if (dbz_m !== 1'b0) begin failures++; $display("[TB] FAIL dbz_clear: got %b expected 0", dbz_m); end
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        int cnt;
        sel16 = 1'b0;
        issue(3'd0, 32'hFFFF_FFFD, 32'd7);
        cnt = 0;
        while (busy_m === 1'b1 && cnt < 200) begin
            cnt++;
            if (cnt == 3) begin op = 3'd3; a = 32'd100; b = 32'd9; start32 = 1'b1; end
            else if (cnt == 9) begin op = 3'd4; a = 32'hDEAD; start32 = 1'b1; end
            else start32 = 1'b0;
            @(negedge clk);
        end
        start32 = 1'b0;
        e = sb_q.pop_front();
        checks++; if (cnt !== e.busy) begin failures++; $display("[TB] FAIL ignore_busy: got %0d expected %0d", cnt, e.busy); end
        checks++; if (done_m !== 1'b1) begin failures++; $display("[TB] FAIL ignore_done: got %b expected 1", done_m); end
        checks++; if ({hi_m, lo_m} !== {e.hi, e.lo}) begin failures++; $display("[TB] FAIL ignore_hilo: got %h expected %h", {hi_m, lo_m}, {e.hi, e.lo}); end
        @(negedge clk);
        checks++; if (busy_m !== 1'b0) begin failures++; $display("[TB] FAIL ignore_idle: got %b expected 0", busy_m); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int cnt;
        sel16 = 1'b0;
        issue(3'd3, 32'd7, 32'd2);
        wait_done(cnt);
        e = sb_q.pop_front();
        checks++; if ({done_m, hi_m, lo_m} !== {1'b1, e.hi, e.lo}) begin failures++; $display("[TB] FAIL b2b_first: got %b/%h/%h expected 1/%h/%h", done_m, hi_m, lo_m, e.hi, e.lo); end
        issue(3'd1, 32'd4, 32'd3);
        wait_done(cnt);
        e = sb_q.pop_front();
        checks++; if (cnt !== e.busy) begin failures++; $display("[TB] FAIL b2b_busy: got %0d expected %0d", cnt, e.busy); end
        checks++; if ({done_m, hi_m, lo_m} !== {1'b1, e.hi, e.lo}) begin failures++; $display("[TB] FAIL b2b_second: got %b/%h/%h expected 1/%h/%h", done_m, hi_m, lo_m, e.hi, e.lo); end
    endtask

    task automatic test_width16();
        logic [2:0]  t_op[7];
        logic [31:0] t_a[7];
        logic [31:0] t_b[7];
        exp_t e;
        int cnt;
        t_op = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd2, 3'd3, 3'd3};
        t_a  = '{32'd5, 32'hFFFF, 32'hFFFD, 32'h8000, 32'hFFF9, 32'd7, 32'd50};
        t_b  = '{32'd4, 32'hFFFF, 32'd7, 32'hFFFF, 32'd2, 32'd2, 32'd0};
        sel16 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            wait_done(cnt);
            e = sb_q.pop_front();
            checks++; if (cnt !== e.busy) begin failures++; $display("[TB] FAIL w16_%0d_busy: got %0d expected %0d", i, cnt, e.busy); end
            checks++; if (done_m !== 1'b1) begin failures++; $display("[TB] FAIL w16_%0d_done: got %b expected 1", i, done_m); end
            checks++; if ({hi_m, lo_m} !== {e.hi, e.lo}) begin failures++; $display("[TB] FAIL w16_%0d_hilo: got %h expected %h", i, {hi_m, lo_m}, {e.hi, e.lo}); end
            checks++; if (dbz_m !== e.dbz) begin failures++; $display("[TB] FAIL w16_%0d_dbz: got %b expected %b", i, dbz_m, e.dbz); end
        end
        sel16 = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int seen;
        sel16 = 1'b0;
        issue(3'd0, 32'd1234, 32'd5678);
        sel16 = 1'b1;
        issue(3'd0, 32'd123, 32'd45);
        sel16 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({busy32, done32, dbz32, hi32, lo32} !== 67'd0) begin failures++; $display("[TB] FAIL midrst_32: got %b/%h/%h expected all 0", {busy32, done32, dbz32}, hi32, lo32); end
        checks++; if ({busy16, done16, dbz16, hi16, lo16} !== 35'd0) begin failures++; $display("[TB] FAIL midrst_16: got %b/%h/%h expected all 0", {busy16, done16, dbz16}, hi16, lo16); end
        sb_q.delete();
        mhi[0] = '0; mlo[0] = '0; mhi[1] = '0; mlo[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done32 !== 1'b0 || done16 !== 1'b0 || busy32 !== 1'b0 || busy16 !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("[TB] FAIL midrst_quiet: got %0d active cycles expected 0", seen); end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_by_zero();
        test_busy_ignore();
        test_back_to_back();
        test_width16();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
